apl_host_model: RTL and testbench
=================================

Name: apl_host_model

Overview:
- Synthesizable host-side loopback model for the stream-buffer top level, used in benches and in FPGA bring-up without a real OpenCAPI link.
- Request path: accepts OpenCAPI requests (sid, ea) into an in-order queue and returns each as a response after a programmable fixed latency.
- URAM path: one independent handshake lane per L2 channel; each lane turns an L2 address (sid, ptr) into a one-hot per-stream URAM response valid.
- Provides outstanding-request and accepted-request counters.

Parameters:
- nstrms, 64, total streams.
- nstrms_width, $clog2(nstrms), stream id width.
- addr_width, 64, effective address width.
- l2_nstrms, 16, streams per L2 channel.
- l2_nstrms_width, $clog2(l2_nstrms), L2 stream id width.
- l2_ncl_width, 8, L2 pointer width.
- channels, nstrms/l2_nstrms, number of L2 channels.
- depth, 8, request queue entries (power of 2, ≥2).
- latency, 4, request-to-response cycles (1..255).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (0 = reset).
- i_req_v  in  1  request valid.
- i_req_r  out  1  request ready.
- i_req_sid  in  nstrms_width  request stream id.
- i_req_ea  in  addr_width  request address.
- o_rsp_v  out  1  response valid.
- o_rsp_r  in  1  response ready.
- o_rsp_sid  out  nstrms_width  response stream id.
- o_rsp_ea  out  addr_width  response address (echo of request).
- i_l2_addr_v  in  channels  L2 address valid, one bit per channel.
- i_l2_addr_r  out  channels  L2 address ready, one bit per channel.
- i_l2_addr_sid  in  channels*l2_nstrms_width  L2 stream id per channel.
- i_l2_addr_ptr  in  channels*l2_ncl_width  L2 pointer per channel.
- o_uram_v  out  nstrms  URAM response valid; bit = k*l2_nstrms + sid.
- i_uram_r  in  nstrms  URAM response ready, same bit mapping.
- o_uram_ptr  out  channels*l2_ncl_width  registered pointer per channel.
- o_outstanding  out  $clog2(depth)+1  current queue occupancy.
- o_req_cnt  out  32  total requests accepted.

Behaviour:
- Reset (reset==0 at a clk edge):
  - Flushes the queue and all channel registers, including mid-operation; in-flight entries are discarded.
  - Drives o_rsp_v=0, o_uram_v=0, o_outstanding=0, o_req_cnt=0, o_rsp_sid/o_rsp_ea/o_uram_ptr=0, i_req_r=0, i_l2_addr_r=0.
  - First cycle after reset release: i_req_r=1, i_l2_addr_r=all ones.
- Request accept:
  - An edge with i_req_v&i_req_r accepts a request.
  - i_req_r = (o_outstanding < depth). No bypass: when full, a same-cycle pop does not free a slot until the next cycle.
- Age tracking:
  - Each entry holds sid, ea and an 8-bit age. Age is written as 1 on accept and increments every edge while < latency. It saturates at latency, including while the entry is stalled.
- Response timing:
  - o_rsp_v = queue non-empty AND head age == latency.
  - Accept at edge N gives o_rsp_v first high after edge N+latency-1. latency=1 behaves as a single register stage.
  - Responses leave in order. Back-to-back accepts produce back-to-back responses when o_rsp_r=1.
- Response hold: while o_rsp_v&!o_rsp_r, o_rsp_sid/o_rsp_ea are held stable and o_rsp_v stays high. Pop occurs on o_rsp_v&o_rsp_r.
- Occupancy: o_outstanding updates on the edge after push/pop. A simultaneous push and pop leaves it unchanged. Read/write pointers wrap modulo depth.
- Request counter: o_req_cnt increments per accept and wraps 0xFFFFFFFF -> 0.
- URAM lane k (one-deep pipelined register per channel):
  - i_l2_addr_r[k] = !valid_k | pop_k.
  - On accept, the lane latches decode(sid) and ptr.
  - o_uram_v[k*l2_nstrms+sid] = valid_k; all other bits of that lane are 0.
  - pop_k = valid_k & i_uram_r[k*l2_nstrms+sid].
  - Simultaneous pop and accept reloads the register with no bubble.
  - Lanes are fully independent.
- Latency: L2 address to o_uram_v is 1 cycle.

Optional Feature:
- Macro: HOST_MODEL_BACKPRESSURE_EN.
- When defined:
  - A 16-bit LFSR (poly x^16+x^14+x^13+x^11+1, seed 0xACE1 on reset) advances every edge.
  - i_req_r is additionally forced low whenever lfsr[1:0]==2'b00.
  - Queue full/empty rules are otherwise unchanged.
- When undefined: no LFSR logic is present and i_req_r follows occupancy only.

Test Plan:
- Reset release, no traffic -> o_rsp_v=0, o_uram_v=0, i_req_r=1, o_outstanding=0, o_req_cnt=0.
- latency=4, single request sid=1 ea=16 accepted at edge N, o_rsp_r=1 -> o_rsp_v high for exactly one cycle after edge N+3 with sid=1, ea=16; o_req_cnt=1.
- depth=8, o_rsp_r=0, 10 back-to-back requests -> 8 accepted, i_req_r=0, o_outstanding=8. Then o_rsp_r=1 -> responses in order sid 0..7, and i_req_r returns 1 the cycle after the first pop.
- Channel 2, sid=5, ptr=0x3C, i_uram_r all ones -> o_uram_v bit 37 high one cycle later, o_uram_ptr lane 2=0x3C. With bit 37 ready low, the lane holds and i_l2_addr_r[2]=0.
- reset asserted low while 3 requests are outstanding -> next cycle o_outstanding=0, o_rsp_v=0; no stale response after release.
- With HOST_MODEL_BACKPRESSURE_EN defined, 1000 random requests -> i_req_r drops at least once, and all accepted sids are returned in order with no loss or duplication.

Source files
------------

// File: rtl/apl_host_model.sv
// Host-side loopback model: in-order request queue with fixed response latency,
// plus one URAM response lane per L2 channel. Optional macro: HOST_MODEL_BACKPRESSURE_EN.
module apl_host_model #(
  parameter int nstrms          = 64,
  parameter int nstrms_width    = $clog2(nstrms),
  parameter int addr_width      = 64,
  parameter int l2_nstrms       = 16,
  parameter int l2_nstrms_width = $clog2(l2_nstrms),
  parameter int l2_ncl_width    = 8,
  parameter int channels        = nstrms / l2_nstrms,
  parameter int depth           = 8,
  parameter int latency         = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  i_req_v,
  output logic                                  i_req_r,
  input  logic [nstrms_width-1:0]               i_req_sid,
  input  logic [addr_width-1:0]                 i_req_ea,
  output logic                                  o_rsp_v,
  input  logic                                  o_rsp_r,
  output logic [nstrms_width-1:0]               o_rsp_sid,
  output logic [addr_width-1:0]                 o_rsp_ea,
  input  logic [channels-1:0]                   i_l2_addr_v,
  output logic [channels-1:0]                   i_l2_addr_r,
  input  logic [channels*l2_nstrms_width-1:0]   i_l2_addr_sid,
  input  logic [channels*l2_ncl_width-1:0]      i_l2_addr_ptr,
  output logic [nstrms-1:0]                     o_uram_v,
  input  logic [nstrms-1:0]                     i_uram_r,
  output logic [channels*l2_ncl_width-1:0]      o_uram_ptr,
  output logic [$clog2(depth):0]                o_outstanding,
  output logic [31:0]                           o_req_cnt
);

  localparam int pw = $clog2(depth);
  localparam logic [7:0] lat8 = 8'(latency);
  localparam logic [pw:0] full_cnt = (pw+1)'(depth);
  localparam logic [l2_nstrms-1:0] one_l2 = l2_nstrms'(1);

  logic                    alive;
  logic [nstrms_width-1:0] sid_q [depth];
  logic [addr_width-1:0]   ea_q  [depth];
  logic [7:0]              age_q [depth];
  logic [pw-1:0]           wr_ptr;
  logic [pw-1:0]           rd_ptr;
  logic [pw:0]             count;
  logic [31:0]             req_cnt;
  logic                    push;
  logic                    pop;
  logic                    head_ready;
  logic                    bp_ok;

`ifdef HOST_MODEL_BACKPRESSURE_EN
  logic [15:0] lfsr;

  // Right-shifting Fibonacci LFSR for x^16+x^14+x^13+x^11+1; throttles request acceptance.
  always_ff @(posedge clk) begin
    if (!reset) lfsr <= 16'hACE1;
    else        lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end

  assign bp_ok = (lfsr[1:0] != 2'b00);
`else
  assign bp_ok = 1'b1;
`endif

  // Ready is held low for the cycle following a reset edge via the alive flag.
  assign i_req_r       = alive & bp_ok & (count < full_cnt);
  assign push          = i_req_v & i_req_r;
  assign head_ready    = (count != '0) && (age_q[rd_ptr] == lat8);
  assign pop           = head_ready & o_rsp_r;
  assign o_rsp_v       = head_ready;
  assign o_rsp_sid     = head_ready ? sid_q[rd_ptr] : '0;
  assign o_rsp_ea      = head_ready ? ea_q[rd_ptr]  : '0;
  assign o_outstanding = count;
  assign o_req_cnt     = req_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      alive   <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      req_cnt <= '0;
      for (int i = 0; i < depth; i++) age_q[i] <= '0;
    end else begin
      alive <= 1'b1;
      // Every slot ages until it saturates at the latency; a push overrides its slot below.
      for (int i = 0; i < depth; i++) begin
        if (age_q[i] < lat8) age_q[i] <= age_q[i] + 8'd1;
      end
      if (push) begin
        sid_q[wr_ptr] <= i_req_sid;
        ea_q[wr_ptr]  <= i_req_ea;
        age_q[wr_ptr] <= 8'd1;
        wr_ptr        <= wr_ptr + pw'(1);
        req_cnt       <= req_cnt + 32'd1;
      end
      if (pop) rd_ptr <= rd_ptr + pw'(1);
      if (push && !pop)      count <= count + (pw+1)'(1);
      else if (pop && !push) count <= count - (pw+1)'(1);
    end
  end

  logic [channels-1:0]     lane_v;
  logic [l2_nstrms-1:0]    lane_oh  [channels];
  logic [l2_ncl_width-1:0] lane_ptr [channels];
  logic [channels-1:0]     lane_pop;
  logic [channels-1:0]     lane_acc;

  always_comb begin
    o_uram_v   = '0;
    o_uram_ptr = '0;
    lane_pop   = '0;
    for (int k = 0; k < channels; k++) begin
      o_uram_v[k*l2_nstrms +: l2_nstrms]        = lane_v[k] ? lane_oh[k] : '0;
      o_uram_ptr[k*l2_ncl_width +: l2_ncl_width] = lane_ptr[k];
      lane_pop[k] = lane_v[k] & (|(lane_oh[k] & i_uram_r[k*l2_nstrms +: l2_nstrms]));
    end
  end

  assign i_l2_addr_r = {channels{alive}} & (~lane_v | lane_pop);
  assign lane_acc    = i_l2_addr_v & i_l2_addr_r;

  // Each lane is a one-deep pipeline register; accept takes priority so pop+accept reloads.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lane_v <= '0;
      for (int k = 0; k < channels; k++) begin
        lane_oh[k]  <= '0;
        lane_ptr[k] <= '0;
      end
    end else begin
      for (int k = 0; k < channels; k++) begin
        if (lane_acc[k]) begin
          lane_v[k]   <= 1'b1;
          lane_oh[k]  <= one_l2 << i_l2_addr_sid[k*l2_nstrms_width +: l2_nstrms_width];
          lane_ptr[k] <= i_l2_addr_ptr[k*l2_ncl_width +: l2_ncl_width];
        end else if (lane_pop[k]) begin
          lane_v[k] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_apl_host_model.sv
// Self-checking bench for apl_host_model: a queue-based reference model checked every cycle,
// directed literal checks, then randomized traffic with occasional resets.
module tb_apl_host_model;

  localparam int NSTRMS = 64;
  localparam int ADDRW  = 64;
  localparam int L2N    = 16;
  localparam int L2W    = 4;
  localparam int PTRW   = 8;
  localparam int CH     = 4;
  localparam int DEPTH  = 8;
  localparam int LAT    = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  i_req_v;
  logic                  i_req_r;
  logic [5:0]            i_req_sid;
  logic [ADDRW-1:0]      i_req_ea;
  logic                  o_rsp_v;
  logic                  o_rsp_r;
  logic [5:0]            o_rsp_sid;
  logic [ADDRW-1:0]      o_rsp_ea;
  logic [CH-1:0]         i_l2_addr_v;
  logic [CH-1:0]         i_l2_addr_r;
  logic [CH*L2W-1:0]     i_l2_addr_sid;
  logic [CH*PTRW-1:0]    i_l2_addr_ptr;
  logic [NSTRMS-1:0]     o_uram_v;
  logic [NSTRMS-1:0]     i_uram_r;
  logic [CH*PTRW-1:0]    o_uram_ptr;
  logic [3:0]            o_outstanding;
  logic [31:0]           o_req_cnt;

  always #5 clk = ~clk;

  apl_host_model #(.depth(DEPTH), .latency(LAT)) dut (
    .clk(clk), .reset(reset),
    .i_req_v(i_req_v), .i_req_r(i_req_r), .i_req_sid(i_req_sid), .i_req_ea(i_req_ea),
    .o_rsp_v(o_rsp_v), .o_rsp_r(o_rsp_r), .o_rsp_sid(o_rsp_sid), .o_rsp_ea(o_rsp_ea),
    .i_l2_addr_v(i_l2_addr_v), .i_l2_addr_r(i_l2_addr_r),
    .i_l2_addr_sid(i_l2_addr_sid), .i_l2_addr_ptr(i_l2_addr_ptr),
    .o_uram_v(o_uram_v), .i_uram_r(i_uram_r), .o_uram_ptr(o_uram_ptr),
    .o_outstanding(o_outstanding), .o_req_cnt(o_req_cnt)
  );

  typedef struct {
    logic [5:0]       sid;
    logic [ADDRW-1:0] ea;
    int               t;
  } req_t;

  // Reference model: a request is eligible once LAT-1 edges have passed since its accept edge.
  req_t        m_q[$];
  bit          m_alive;
  int          m_edge;
  logic [31:0] m_cnt;
  logic        m_lv   [CH];
  logic [3:0]  m_lsid [CH];
  logic [7:0]  m_lptr [CH];
`ifdef HOST_MODEL_BACKPRESSURE_EN
  logic [15:0] m_lfsr;
`endif

  logic              exp_req_r;
  logic              exp_rsp_v;
  logic [5:0]        exp_sid;
  logic [ADDRW-1:0]  exp_ea;
  logic [3:0]        exp_out;
  logic [NSTRMS-1:0] exp_uram_v;
  logic [CH*PTRW-1:0] exp_ptr;
  logic [CH-1:0]     exp_addr_r;

  int n_vec = 0;
  int n_err = 0;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compute_expected();
    bit bp_ok = 1'b1;
`ifdef HOST_MODEL_BACKPRESSURE_EN
    bp_ok = (m_lfsr[1:0] != 2'b00);
`endif
    exp_req_r = m_alive && (m_q.size() < DEPTH) && bp_ok;
    exp_rsp_v = 1'b0;
    exp_sid   = '0;
    exp_ea    = '0;
    if (m_q.size() > 0) begin
      if (m_edge - m_q[0].t >= LAT - 1) begin
        exp_rsp_v = 1'b1;
        exp_sid   = m_q[0].sid;
        exp_ea    = m_q[0].ea;
      end
    end
    exp_out    = 4'(m_q.size());
    exp_uram_v = '0;
    exp_ptr    = '0;
    exp_addr_r = '0;
    for (int k = 0; k < CH; k++) begin
      int bitn = k * L2N + int'(m_lsid[k]);
      if (m_lv[k]) exp_uram_v[bitn] = 1'b1;
      exp_ptr[k*PTRW +: PTRW] = m_lptr[k];
      exp_addr_r[k] = m_alive && (!m_lv[k] || i_uram_r[bitn]);
    end
  endtask

  task automatic check_output();
    compute_expected();
    cmp("req_r",       64'(i_req_r),       64'(exp_req_r));
    cmp("rsp_v",       64'(o_rsp_v),       64'(exp_rsp_v));
    cmp("rsp_sid",     64'(o_rsp_sid),     64'(exp_sid));
    cmp("rsp_ea",      o_rsp_ea,           exp_ea);
    cmp("outstanding", 64'(o_outstanding), 64'(exp_out));
    cmp("req_cnt",     64'(o_req_cnt),     64'(m_cnt));
    cmp("uram_v",      o_uram_v,           exp_uram_v);
    cmp("uram_ptr",    64'(o_uram_ptr),    64'(exp_ptr));
    cmp("l2_addr_r",   64'(i_l2_addr_r),   64'(exp_addr_r));
  endtask

  // Advance the model across the upcoming clock edge using the currently driven inputs.
  task automatic model_step();
    if (!reset) begin
      m_q.delete();
      m_alive = 1'b0;
      m_cnt   = '0;
      for (int k = 0; k < CH; k++) begin
        m_lv[k] = 1'b0; m_lsid[k] = '0; m_lptr[k] = '0;
      end
`ifdef HOST_MODEL_BACKPRESSURE_EN
      m_lfsr = 16'hACE1;
`endif
    end else begin
      compute_expected();
      if (exp_rsp_v && o_rsp_r) void'(m_q.pop_front());
      if (i_req_v && exp_req_r) begin
        m_q.push_back('{sid: i_req_sid, ea: i_req_ea, t: m_edge + 1});
        m_cnt = m_cnt + 32'd1;
      end
      for (int k = 0; k < CH; k++) begin
        bit lpop = m_lv[k] && i_uram_r[k*L2N + int'(m_lsid[k])];
        if (i_l2_addr_v[k] && exp_addr_r[k]) begin
          m_lv[k]   = 1'b1;
          m_lsid[k] = i_l2_addr_sid[k*L2W +: L2W];
          m_lptr[k] = i_l2_addr_ptr[k*PTRW +: PTRW];
        end else if (lpop) begin
          m_lv[k] = 1'b0;
        end
      end
      m_alive = 1'b1;
`ifdef HOST_MODEL_BACKPRESSURE_EN
      m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
`endif
    end
    m_edge++;
  endtask

  task automatic apply_stimulus();
    #1;
    check_output();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; i_req_v = 1'b0; i_req_sid = '0; i_req_ea = '0; o_rsp_r = 1'b0;
    i_l2_addr_v = '0; i_l2_addr_sid = '0; i_l2_addr_ptr = '0; i_uram_r = '1;
    m_edge = 0;
    model_step();
    @(posedge clk);
    @(negedge clk);
    apply_stimulus();
    apply_stimulus();

    reset = 1'b1;
    apply_stimulus();

`ifndef HOST_MODEL_BACKPRESSURE_EN
    cmp("idle_req_r",       64'(i_req_r),       64'd1);
    cmp("idle_rsp_v",       64'(o_rsp_v),       64'd0);
    cmp("idle_uram_v",      o_uram_v,           64'd0);
    cmp("idle_outstanding", 64'(o_outstanding), 64'd0);
    cmp("idle_req_cnt",     64'(o_req_cnt),     64'd0);

    // Single request: response appears after edge N+3 for one cycle.
    o_rsp_r = 1'b1;
    i_req_v = 1'b1; i_req_sid = 6'd1; i_req_ea = 64'd16;
    apply_stimulus();
    i_req_v = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cmp("single_early_v", 64'(o_rsp_v), 64'd0);
      apply_stimulus();
    end
    cmp("single_v",   64'(o_rsp_v),   64'd1);
    cmp("single_sid", 64'(o_rsp_sid), 64'd1);
    cmp("single_ea",  o_rsp_ea,       64'd16);
    cmp("single_cnt", 64'(o_req_cnt), 64'd1);
    apply_stimulus();
    cmp("single_done_v", 64'(o_rsp_v), 64'd0);

    // Fill beyond depth with responses blocked, then drain in order.
    o_rsp_r = 1'b0;
    for (int i = 0; i < 10; i++) begin
      i_req_v = 1'b1; i_req_sid = 6'(i); i_req_ea = 64'(i) << 4;
      apply_stimulus();
    end
    i_req_v = 1'b0;
    cmp("full_outstanding", 64'(o_outstanding), 64'd8);
    cmp("full_req_r",       64'(i_req_r),       64'd0);
    cmp("full_cnt",         64'(o_req_cnt),     64'd9);
    o_rsp_r = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cmp("drain_v",   64'(o_rsp_v),   64'd1);
      cmp("drain_sid", 64'(o_rsp_sid), 64'(i));
      apply_stimulus();
      if (i == 0) cmp("drain_req_r", 64'(i_req_r), 64'd1);
    end
    cmp("drain_empty_v", 64'(o_rsp_v), 64'd0);

    // URAM lane 2, sid 5, ptr 0x3C maps to bit 37.
    i_l2_addr_v = 4'b0100;
    i_l2_addr_sid = 16'h0500;
    i_l2_addr_ptr = 32'h003C_0000;
    apply_stimulus();
    i_l2_addr_v = '0;
    cmp("uram_bit37", o_uram_v,        64'h0000_0020_0000_0000);
    cmp("uram_ptr2",  64'(o_uram_ptr), 64'h0000_0000_003C_0000);
    i_uram_r = ~(64'd1 << 37);
    apply_stimulus();
    cmp("uram_hold_v", o_uram_v,              64'h0000_0020_0000_0000);
    cmp("uram_hold_r", 64'(i_l2_addr_r[2]),   64'd0);
    i_uram_r = '1;
    apply_stimulus();
    cmp("uram_pop_v", o_uram_v, 64'd0);

    // Reset with three requests in flight.
    o_rsp_r = 1'b0;
    for (int i = 0; i < 3; i++) begin
      i_req_v = 1'b1; i_req_sid = 6'(10 + i); i_req_ea = 64'(100 + i);
      apply_stimulus();
    end
    i_req_v = 1'b0;
    cmp("pre_rst_outstanding", 64'(o_outstanding), 64'd3);
    reset = 1'b0;
    apply_stimulus();
    cmp("rst_outstanding", 64'(o_outstanding), 64'd0);
    cmp("rst_rsp_v",       64'(o_rsp_v),       64'd0);
    cmp("rst_req_r",       64'(i_req_r),       64'd0);
    reset = 1'b1; o_rsp_r = 1'b1;
    for (int i = 0; i < 6; i++) begin
      apply_stimulus();
      cmp("rst_no_stale", 64'(o_rsp_v), 64'd0);
    end
`endif

    // Randomized traffic against the reference model.
    for (int c = 0; c < 1000; c++) begin
      reset         = ($urandom_range(0, 199) != 0);
      i_req_v       = ($urandom_range(0, 3) != 0);
      i_req_sid     = 6'($urandom);
      i_req_ea      = {$urandom, $urandom};
      o_rsp_r       = ($urandom_range(0, 9) < 7);
      i_l2_addr_v   = 4'($urandom);
      i_l2_addr_sid = 16'($urandom);
      i_l2_addr_ptr = $urandom;
      i_uram_r      = {$urandom, $urandom} | {$urandom, $urandom};
      apply_stimulus();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
